// File: rtl/clock_pkg.sv
// Shared definitions for the mm:ss clock-setting controller: mode
// encodings, BCD digit limits and small mode helpers.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'b00,
      MODE_SET_MIN = 2'b01,
      MODE_SET_SEC = 2'b10,
      MODE_INVALID = 2'b11
   } mode_t;

   // Largest legal value of a ones digit and of a tens digit (mod 60).
   localparam logic [3:0] UNITS_MAX = 4'd9;
   localparam logic [2:0] TENS_MAX  = 3'd5;

   // Mode sequence on each mode press; anything unexpected falls back to RUN.
   function automatic mode_t advance_mode(input mode_t cur);
      mode_t nxt;
      case (cur)
         MODE_RUN:     nxt = MODE_SET_MIN;
         MODE_SET_MIN: nxt = MODE_SET_SEC;
         default:      nxt = MODE_RUN;
      endcase
      return nxt;
   endfunction

   // True for the two editing modes.
   function automatic logic is_set_mode(input mode_t m);
      return (m == MODE_SET_MIN) || (m == MODE_SET_SEC);
   endfunction

endpackage

// File: rtl/clock_set_controller_bcd_mod60.sv
// Two-digit BCD counter modulo 60 with increment, decrement and a
// combinational carry-out flagging an increment that wraps 59 -> 00.
module bcd_mod60
   import clock_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] units,
   output logic [2:0] tens,
   output logic       carry
);

   logic [3:0] units_reg, units_next;
   logic [2:0] tens_reg, tens_next;

   // Next digit values; simultaneous inc and dec leave the value unchanged.
   always_comb begin
      units_next = units_reg;
      tens_next  = tens_reg;
      if (inc && !dec) begin
         if (units_reg == UNITS_MAX) begin
            units_next = 4'd0;
            tens_next  = (tens_reg == TENS_MAX) ? 3'd0 : tens_reg + 3'd1;
         end else begin
            units_next = units_reg + 4'd1;
         end
      end else if (dec && !inc) begin
         if (units_reg == 4'd0) begin
            units_next = UNITS_MAX;
            tens_next  = (tens_reg == 3'd0) ? TENS_MAX : tens_reg - 3'd1;
         end else begin
            units_next = units_reg - 4'd1;
         end
      end
   end

   // Digit registers, cleared immediately by the active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         units_reg <= 4'd0;
         tens_reg  <= 3'd0;
      end else begin
         units_reg <= units_next;
         tens_reg  <= tens_next;
      end
   end

   assign carry = inc && !dec && (units_reg == UNITS_MAX) && (tens_reg == TENS_MAX);
   assign units = units_reg;
   assign tens  = tens_reg;

endmodule

// File: rtl/clock_set_controller.sv
// mm:ss clock with a RUN mode driven by a 1 s prescaler and two edit
// modes (minutes, seconds) that freeze time and blink the edited field.
module clock_set_controller
   import clock_pkg::*;
#(
   parameter int TICK_DIV  = 100000000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_press,
   input  logic       inc_press,
   input  logic       dec_press,
   output logic [3:0] seconds_units,
   output logic [2:0] seconds_tens,
   output logic [3:0] minutes_units,
   output logic [2:0] minutes_tens,
   output logic [3:0] blank_mask,
   output logic [1:0] mode
);

   localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   mode_t               state_reg, state_next;
   logic [TICK_W-1:0]   prescale_reg, prescale_next;
   logic                tick;
   logic [BLINK_W-1:0]  blink_cnt_reg, blink_cnt_next;
   logic                blink_phase_reg, blink_phase_next;
   logic [3:0]          blank_reg, blank_next;

   logic edit_inc, edit_dec, edit_accept;
   logic sec_inc, sec_dec, sec_carry;
   logic min_inc, min_dec, min_carry;

   // A mode press wins over any edit pulse; inc together with dec is no edit.
   assign edit_inc    = inc_press && !dec_press && !mode_press;
   assign edit_dec    = dec_press && !inc_press && !mode_press;
   assign edit_accept = is_set_mode(state_reg) && (edit_inc || edit_dec);

   // Mode sequencing, with recovery from the unused encoding.
   always_comb begin
      state_next = state_reg;
      if (state_reg == MODE_INVALID) begin
         state_next = MODE_RUN;
      end else if (mode_press) begin
         state_next = advance_mode(state_reg);
      end
   end

   // Mode register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= MODE_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Prescaler runs only in RUN; held at zero elsewhere so a return to RUN
   // always waits a full tick period.
   always_comb begin
      prescale_next = '0;
      tick          = 1'b0;
      if (state_reg == MODE_RUN) begin
         if (prescale_reg == TICK_LAST) begin
            tick = 1'b1;
         end else begin
            prescale_next = prescale_reg + TICK_W'(1);
         end
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescale_reg <= '0;
      end else begin
         prescale_reg <= prescale_next;
      end
   end

   // Steering of tick and edit pulses into the two mod-60 fields.
   always_comb begin
      sec_inc = tick || ((state_reg == MODE_SET_SEC) && edit_inc);
      sec_dec = (state_reg == MODE_SET_SEC) && edit_dec;
      min_inc = (tick && sec_carry) || ((state_reg == MODE_SET_MIN) && edit_inc);
      min_dec = (state_reg == MODE_SET_MIN) && edit_dec;
   end

   bcd_mod60 u_seconds (
      .clk   (clk),
      .reset (reset),
      .inc   (sec_inc),
      .dec   (sec_dec),
      .units (seconds_units),
      .tens  (seconds_tens),
      .carry (sec_carry)
   );

   bcd_mod60 u_minutes (
      .clk   (clk),
      .reset (reset),
      .inc   (min_inc),
      .dec   (min_dec),
      .units (minutes_units),
      .tens  (minutes_tens),
      .carry (min_carry)
   );

   // Blink timing: restart visible on entering a set mode or after an edit,
   // otherwise toggle the phase every BLINK_DIV cycles while editing.
   always_comb begin
      blink_cnt_next   = '0;
      blink_phase_next = 1'b0;
      if (is_set_mode(state_next) && (state_next == state_reg) && !edit_accept) begin
         if (blink_cnt_reg == BLINK_LAST) begin
            blink_phase_next = ~blink_phase_reg;
         end else begin
            blink_cnt_next   = blink_cnt_reg + BLINK_W'(1);
            blink_phase_next = blink_phase_reg;
         end
      end
   end

   // Blank request follows the mode and phase that take effect at this edge.
   always_comb begin
      blank_next = 4'b0000;
      case (state_next)
         MODE_SET_MIN: blank_next = blink_phase_next ? 4'b1100 : 4'b0000;
         MODE_SET_SEC: blank_next = blink_phase_next ? 4'b0011 : 4'b0000;
         default:      blank_next = 4'b0000;
      endcase
   end

   // Blink counter, phase and registered blank mask.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt_reg   <= '0;
         blink_phase_reg <= 1'b0;
         blank_reg       <= 4'b0000;
      end else begin
         blink_cnt_reg   <= blink_cnt_next;
         blink_phase_reg <= blink_phase_next;
         blank_reg       <= blank_next;
      end
   end

   // The minutes carry has no destination: hours are not kept.
   logic unused_min_carry;
   assign unused_min_carry = min_carry;

   assign blank_mask = blank_reg;
   assign mode       = state_reg;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with TICK_DIV=10, BLINK_DIV=4.
// Time is compared as the decimal number mm*100+ss.
module tb_clock_set_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       mode_press = 1'b0;
   logic       inc_press = 1'b0;
   logic       dec_press = 1'b0;
   logic [3:0] seconds_units;
   logic [2:0] seconds_tens;
   logic [3:0] minutes_units;
   logic [2:0] minutes_tens;
   logic [3:0] blank_mask;
   logic [1:0] mode;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   clock_set_controller #(
      .TICK_DIV  (10),
      .BLINK_DIV (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .mode_press    (mode_press),
      .inc_press     (inc_press),
      .dec_press     (dec_press),
      .seconds_units (seconds_units),
      .seconds_tens  (seconds_tens),
      .minutes_units (minutes_units),
      .minutes_tens  (minutes_tens),
      .blank_mask    (blank_mask),
      .mode          (mode)
   );

   task automatic check_val(input string tag, input int observed, input int expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end else begin
         $display("ok   %s: %0d", tag, observed);
      end
   endtask

   function automatic int time_now();
      return int'(minutes_tens) * 1000 + int'(minutes_units) * 100
           + int'(seconds_tens) * 10 + int'(seconds_units);
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic m, input logic i, input logic d);
      mode_press = m;
      inc_press  = i;
      dec_press  = d;
      step(1);
      mode_press = 1'b0;
      inc_press  = 1'b0;
      dec_press  = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      check_val("reset_mode", int'(mode), 0);
      check_val("reset_time", time_now(), 0);
      check_val("reset_blank", int'(blank_mask), 0);
      step(2);
      reset = 1'b1;

      // First tick exactly 10 cycles after release; 600 cycles -> 01:00
      step(9);
      check_val("first_tick_early", time_now(), 0);
      step(1);
      check_val("first_tick", time_now(), 1);
      step(590);
      check_val("run_600", time_now(), 100);
      check_val("run_mode", int'(mode), 0);
      check_val("run_blank", int'(blank_mask), 0);

      // Edits ignored in RUN
      pulse(0, 1, 0);
      check_val("run_ignore_inc", time_now(), 100);
      pulse(0, 0, 1);
      check_val("run_ignore_dec", time_now(), 100);

      // SET_MIN: 01 -> 00 -> 59; SET_SEC: 00 -> 59; back to RUN
      pulse(1, 0, 0);
      check_val("enter_set_min", int'(mode), 1);
      pulse(0, 0, 1);
      check_val("min_dec_01", time_now(), 0);
      pulse(0, 0, 1);
      check_val("min_dec_wrap", time_now(), 5900);
      pulse(1, 0, 0);
      check_val("enter_set_sec", int'(mode), 2);
      pulse(0, 0, 1);
      check_val("sec_dec_wrap", time_now(), 5959);
      pulse(1, 0, 0);
      check_val("back_to_run", int'(mode), 0);
      step(9);
      check_val("run_hold_9", time_now(), 5959);
      step(1);
      check_val("wrap_5959", time_now(), 0);

      // SET_SEC at 00:59, inc wraps seconds without carry
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      check_val("set_sec_again", int'(mode), 2);
      pulse(0, 0, 1);
      check_val("sec_to_59", time_now(), 59);
      pulse(0, 1, 0);
      check_val("sec_wrap_no_carry", time_now(), 0);
      pulse(0, 1, 0);
      check_val("sec_inc", time_now(), 1);
      pulse(0, 1, 1);
      check_val("inc_dec_together", time_now(), 1);

      // Blink pattern in SET_MIN
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      check_val("blink_mode", int'(mode), 1);
      check_val("blink_entry", int'(blank_mask), 0);
      step(3);
      check_val("blink_k3", int'(blank_mask), 0);
      step(1);
      check_val("blink_k4", int'(blank_mask), 12);
      step(3);
      check_val("blink_k7", int'(blank_mask), 12);
      step(1);
      check_val("blink_k8", int'(blank_mask), 0);
      step(4);
      check_val("blink_k12", int'(blank_mask), 12);
      pulse(0, 1, 0);
      check_val("blink_after_inc", int'(blank_mask), 0);
      check_val("min_inc", time_now(), 101);
      step(3);
      check_val("blink_restart_k3", int'(blank_mask), 0);
      step(1);
      check_val("blink_restart_k4", int'(blank_mask), 12);

      // mode_press wins over inc_press
      pulse(1, 1, 0);
      check_val("priority_mode", int'(mode), 2);
      check_val("priority_time", time_now(), 101);

      // Set 12:34, then reset asynchronously in SET_SEC
      pulse(1, 0, 0);
      pulse(1, 0, 0);
      repeat (11) pulse(0, 1, 0);
      pulse(1, 0, 0);
      repeat (33) pulse(0, 1, 0);
      check_val("preset_time", time_now(), 1234);
      check_val("preset_mode", int'(mode), 2);
      #2;
      reset = 1'b0;
      #1;
      check_val("async_mode", int'(mode), 0);
      check_val("async_time", time_now(), 0);
      check_val("async_blank", int'(blank_mask), 0);
      step(2);
      reset = 1'b1;
      step(9);
      check_val("rerelease_early", time_now(), 0);
      step(1);
      check_val("rerelease_tick", time_now(), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per 1 s time tick.
REQ-002 Parameter BLINK_DIV, default 25000000, clk cycles per blink-phase toggle.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-005 mode_press  input  1  single-cycle pulse, already synchronized and debounced; advances mode.
REQ-006 inc_press  input  1  single-cycle pulse; increments the field being edited.
REQ-007 dec_press  input  1  single-cycle pulse; decrements the field being edited.
REQ-008 seconds_units  output  4  seconds ones digit, 0-9.
REQ-009 seconds_tens  output  3  seconds tens digit, 0-5.
REQ-010 minutes_units  output  4  minutes ones digit, 0-9.
REQ-011 minutes_tens  output  3  minutes tens digit, 0-5.
REQ-012 blank_mask  output  4  per-digit blank request: bit0 sec units, bit1 sec tens, bit2 min units, bit3 min tens; 1 means blanked.
REQ-013 mode  output  2  current state: 00 RUN, 01 SET_MIN, 10 SET_SEC.

Function
REQ-014 The FSM SHALL have three states: RUN, SET_MIN and SET_SEC. Encoding 11 is unreachable and SHALL recover to RUN on the next clk.
REQ-015 Each mode_press SHALL advance the state on the next clk: RUN to SET_MIN, SET_MIN to SET_SEC, SET_SEC to RUN.
REQ-016 In RUN, the prescaler SHALL count 0 to TICK_DIV-1 and wrap. The cycle at TICK_DIV-1 SHALL advance the time by 1 s, visible on the next clk.
REQ-017 RUN counting SHALL be BCD mm:ss modulo 60:60. 59:59 SHALL wrap to 00:00. Seconds 59 to 00 SHALL carry +1 into minutes.
REQ-018 In SET_MIN and SET_SEC, time SHALL be frozen and the prescaler held at 0. On return to RUN, the first tick SHALL occur TICK_DIV cycles later.
REQ-019 In SET_MIN, inc_press/dec_press SHALL change minutes by +1/-1 modulo 60 (59 to 00, 00 to 59), visible next clk.
REQ-020 In SET_SEC, inc_press/dec_press SHALL change seconds by +1/-1 modulo 60, with no carry or borrow into minutes.
REQ-021 In RUN, inc_press and dec_press SHALL be ignored.
REQ-022 inc_press and dec_press asserted in the same cycle SHALL be ignored.
REQ-023 mode_press asserted with inc_press or dec_press SHALL take priority; the edit pulse SHALL be dropped.
REQ-024 The blink phase SHALL toggle every BLINK_DIV cycles while in a SET state.
REQ-025 The blink phase SHALL reset to 0 (visible) on entry to each SET state and on every accepted inc/dec.
REQ-026 blank_mask SHALL be:
- 0000 in RUN;
- 1100 in SET_MIN when phase=1, else 0000;
- 0011 in SET_SEC when phase=1, else 0000.
REQ-027 All outputs SHALL be registered. Latency from pulse to output change SHALL be exactly 1 clk.

Reset
REQ-028 While reset=0, all digits SHALL be 0, mode=00, blank_mask=0000, and the prescaler, blink counter and blink phase SHALL be 0.
REQ-029 Reset asserted mid-edit or mid-tick SHALL take effect asynchronously, with no partial update retained.
REQ-030 After reset deasserts, the first tick SHALL occur TICK_DIV cycles later.

Structure
REQ-031 The mode encodings (RUN/SET_MIN/SET_SEC) and digit limits (9, 5) SHALL live in shared package clock_pkg.
REQ-032 One sub-module, bcd_mod60, SHALL be instantiated twice (seconds, minutes): inc/dec/carry-out, 2-digit BCD modulo 60.

Verification (TICK_DIV=10, BLINK_DIV=4)
REQ-033 Release reset, run 600 clk -> time reads 01:00, mode=00, blank_mask=0000.
REQ-034 Enter SET_MIN, one dec_press (00 to 59); enter SET_SEC, one dec_press (00 to 59); return to RUN -> 10 clk later time reads 00:00.
REQ-035 In SET_SEC at xx:59, inc_press -> seconds 00, minutes unchanged, next clk.
REQ-036 In SET_MIN, idle -> blank_mask alternates 0000/1100 every 4 clk; inc_press -> blank_mask 0000 next clk, and the phase restarts.
REQ-037 inc_press+dec_press together in SET_SEC -> no change; mode_press+inc_press in SET_MIN -> mode=10, minutes unchanged.
REQ-038 reset=0 during SET_SEC at 12:34 -> immediately mode=00, time 00:00, blank_mask=0000.
